// File: rtl/bus_bridge_initiator_uart_link.sv
// Bus-B side UART link: reassembles 4-byte request frames from the UART
// receiver into a parallel request, and serialises 2-byte responses back
// out through the UART transmitter.
module bus_bridge_initiator_uart_link #(
  parameter int unsigned FRAME_TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx_ready,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_ready_clr,
  output logic [7:0]  uart_tx_data,
  output logic        uart_wr_en,
  input  logic        uart_tx_busy,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [15:0] req_addr,
  output logic [7:0]  req_wdata,
  output logic        req_is_write,
  input  logic        resp_valid,
  output logic        resp_ready,
  input  logic [7:0]  resp_rdata,
  input  logic        resp_is_write,
  output logic        err_timeout,
  output logic        err_overrun
);

  localparam int unsigned     CNT_W    = $clog2(FRAME_TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    RX_ADDR_L, RX_ADDR_H, RX_DATA, RX_FLAGS, RX_HOLD
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_SEND_DATA, TX_WAIT_DATA, TX_SEND_FLAGS, TX_WAIT_FLAGS
  } tx_state_t;

  rx_state_t        rx_state, rx_next;
  tx_state_t        tx_state, tx_next;
  logic             rx_q;
  logic             byte_det;
  logic             rx_counting;
  logic             to_fire;
  logic [CNT_W-1:0] to_cnt;
  logic             busy_d;
  logic             tx_done;
  logic             resp_fire;
  logic             wr_en_d;
  logic [7:0]       tx_byte_d;
  logic [7:0]       rdata_q;
  logic             is_write_q;

  assign byte_det = uart_rx_ready && !rx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q           <= 1'b0;
      uart_ready_clr <= 1'b0;
      busy_d         <= 1'b0;
    end else begin
      rx_q           <= uart_rx_ready;
      uart_ready_clr <= byte_det;
      busy_d         <= uart_tx_busy;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rx_state <= RX_ADDR_L;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_ADDR_L: if (byte_det) rx_next = RX_ADDR_H;
      RX_ADDR_H: if (byte_det) rx_next = RX_DATA;  else if (to_fire) rx_next = RX_ADDR_L;
      RX_DATA:   if (byte_det) rx_next = RX_FLAGS; else if (to_fire) rx_next = RX_ADDR_L;
      RX_FLAGS:  if (byte_det) rx_next = RX_HOLD;  else if (to_fire) rx_next = RX_ADDR_L;
      RX_HOLD:   if (req_ready) rx_next = RX_ADDR_L;
      default:   rx_next = RX_ADDR_L;
    endcase
  end

  always_comb begin
    req_valid   = (rx_state == RX_HOLD);
    rx_counting = (rx_state == RX_ADDR_H) || (rx_state == RX_DATA) || (rx_state == RX_FLAGS);
    to_fire     = rx_counting && !byte_det && (to_cnt == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt       <= '0;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_is_write <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      if (byte_det || to_fire)                 to_cnt <= '0;
      else if (rx_counting && to_cnt != '1)    to_cnt <= to_cnt + 1'b1;
      if (byte_det) begin
        case (rx_state)
          RX_ADDR_L: req_addr[7:0]  <= uart_rx_data;
          RX_ADDR_H: req_addr[15:8] <= uart_rx_data;
          RX_DATA:   req_wdata      <= uart_rx_data;
          RX_FLAGS:  req_is_write   <= uart_rx_data[0];
          default:   err_overrun    <= 1'b1;
        endcase
      end
      if (to_fire) err_timeout <= 1'b1;
    end
  end

  // resp_ready is registered from tx_next so it stays low through reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state   <= TX_IDLE;
      resp_ready <= 1'b0;
    end else begin
      tx_state   <= tx_next;
      resp_ready <= (tx_next == TX_IDLE);
    end
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:       if (resp_fire)     tx_next = TX_SEND_DATA;
      TX_SEND_DATA:  if (!uart_tx_busy) tx_next = TX_WAIT_DATA;
      TX_WAIT_DATA:  if (tx_done)       tx_next = TX_SEND_FLAGS;
      TX_SEND_FLAGS: if (!uart_tx_busy) tx_next = TX_WAIT_FLAGS;
      TX_WAIT_FLAGS: if (tx_done)       tx_next = TX_IDLE;
      default:       tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    resp_fire = resp_valid && resp_ready;
    tx_done   = busy_d && !uart_tx_busy;
    wr_en_d   = ((tx_state == TX_SEND_DATA) || (tx_state == TX_SEND_FLAGS)) && !uart_tx_busy;
    tx_byte_d = (tx_state == TX_SEND_DATA) ? rdata_q : {7'b0, is_write_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q      <= '0;
      is_write_q   <= 1'b0;
      uart_wr_en   <= 1'b0;
      uart_tx_data <= '0;
    end else begin
      if (tx_state == TX_IDLE && resp_fire) begin
        rdata_q    <= resp_rdata;
        is_write_q <= resp_is_write;
      end
      uart_wr_en <= wr_en_d;
      if (wr_en_d) uart_tx_data <= tx_byte_d;
    end
  end

endmodule

// File: tb/tb_bus_bridge_initiator_uart_link.sv
// Directed bench for the far-end UART link, with a simple UART transmitter
// busy model and monitors logging requests and transmitted bytes.
module tb_bus_bridge_initiator_uart_link;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx_ready = 1'b0;
  logic [7:0]  uart_rx_data = 8'h00;
  logic        uart_ready_clr;
  logic [7:0]  uart_tx_data;
  logic        uart_wr_en;
  logic        uart_tx_busy = 1'b0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_is_write;
  logic        resp_valid = 1'b0;
  logic        resp_ready;
  logic [7:0]  resp_rdata = 8'h00;
  logic        resp_is_write = 1'b0;
  logic        err_timeout;
  logic        err_overrun;

  int checks = 0;
  int errors = 0;

  int cyc = 0, clr_cnt = 0, req_cnt = 0, wr_cnt = 0;
  int wr_busy_viol = 0, wr_double = 0, busy_cnt = 0, hs_cyc = 0;
  logic prev_wr = 1'b0, busy_pend = 1'b0;
  logic [15:0] req_addr_log  [0:63];
  logic [7:0]  req_wdata_log [0:63];
  logic        req_isw_log   [0:63];
  logic [7:0]  tx_log        [0:63];
  int          wr_cyc_log    [0:63];

  bus_bridge_initiator_uart_link #(.FRAME_TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .uart_rx_ready(uart_rx_ready), .uart_rx_data(uart_rx_data),
    .uart_ready_clr(uart_ready_clr), .uart_tx_data(uart_tx_data),
    .uart_wr_en(uart_wr_en), .uart_tx_busy(uart_tx_busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_is_write(req_is_write),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_is_write(resp_is_write),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // Monitors plus UART transmitter model: busy rises the cycle after a
  // write strobe and stays high for six cycles.
  always @(negedge clk) begin
    cyc++;
    if (uart_ready_clr) clr_cnt++;
    if (req_valid && req_ready) begin
      if (req_cnt < 64) begin
        req_addr_log[req_cnt]  = req_addr;
        req_wdata_log[req_cnt] = req_wdata;
        req_isw_log[req_cnt]   = req_is_write;
      end
      req_cnt++;
    end
    if (resp_valid && resp_ready) hs_cyc = cyc;
    if (uart_wr_en) begin
      if (uart_tx_busy) wr_busy_viol++;
      if (prev_wr) wr_double++;
      if (wr_cnt < 64) begin
        tx_log[wr_cnt]     = uart_tx_data;
        wr_cyc_log[wr_cnt] = cyc;
      end
      wr_cnt++;
    end
    prev_wr = uart_wr_en;
    if (busy_pend) begin
      busy_cnt  = 6;
      busy_pend = 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    if (uart_wr_en) busy_pend = 1'b1;
    uart_tx_busy = (busy_cnt != 0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    uart_rx_ready = 1'b0;
    uart_rx_data = 8'h00;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 8'h00;
    resp_is_write = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // Byte is detected at the first edge; the UART flag drops one cycle after
  // the clear pulse; returns with the link ready to detect the next byte.
  task automatic send_byte(input logic [7:0] b);
    uart_rx_data = b;
    uart_rx_ready = 1'b1;
    tick(1);
    tick(1);
    uart_rx_ready = 1'b0;
    tick(1);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic start_resp(input logic [7:0] d, input logic w, output int ok);
    resp_rdata = d;
    resp_is_write = w;
    resp_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && ok == 0; i++) begin
      if (resp_ready) ok = 1;
      tick(1);
    end
    resp_valid = 1'b0;
    resp_rdata = 8'hFF;
    resp_is_write = ~w;
  endtask

  task automatic wait_tx(input int w0, output int premature, output int ok);
    ok = 0;
    premature = 0;
    for (int i = 0; i < 200 && ok == 0; i++) begin
      tick(1);
      if ((wr_cnt - w0) >= 2 && resp_ready) ok = 1;
      else if (resp_ready) premature++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
    checks++; if (req_addr !== 16'h0000) begin errors++; $display("FAIL reset_req_addr: got %h want 0000", req_addr); end
    checks++; if (uart_wr_en !== 1'b0 || uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx: got wr %b data %h want 0 00", uart_wr_en, uart_tx_data); end
    checks++; if (resp_ready !== 1'b0) begin errors++; $display("FAIL reset_resp_ready: got %b want 0", resp_ready); end
    checks++; if ({err_timeout, err_overrun, uart_ready_clr} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {err_timeout, err_overrun, uart_ready_clr}); end
    rst_n = 1'b1;
    tick(1);
    checks++; if (resp_ready !== 1'b1) begin errors++; $display("FAIL reset_release_resp_ready: got %b want 1", resp_ready); end
  endtask

  task automatic test_write_frame();
    int r0, c0;
    do_reset();
    req_ready = 1'b1;
    r0 = req_cnt;
    c0 = clr_cnt;
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'hAB);
    uart_rx_data = 8'h01;
    uart_rx_ready = 1'b1;
    tick(1);
    checks++; if (req_valid !== 1'b1 || uart_ready_clr !== 1'b1) begin errors++; $display("FAIL wr_flags_latency: got valid %b clr %b want 1 1", req_valid, uart_ready_clr); end
    tick(1);
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL wr_valid_after_hs: got %b want 0", req_valid); end
    uart_rx_ready = 1'b0;
    tick(2);
    checks++; if (req_cnt - r0 !== 1) begin errors++; $display("FAIL wr_req_count: got %0d want 1", req_cnt - r0); end
    checks++; if (req_addr_log[r0] !== 16'h1234 || req_wdata_log[r0] !== 8'hAB || req_isw_log[r0] !== 1'b1) begin
      errors++; $display("FAIL wr_payload: got %h %h %b want 1234 ab 1", req_addr_log[r0], req_wdata_log[r0], req_isw_log[r0]); end
    checks++; if (clr_cnt - c0 !== 4) begin errors++; $display("FAIL wr_clr_count: got %0d want 4", clr_cnt - c0); end
  endtask

  task automatic test_read_response();
    int w0, ok, prem;
    do_reset();
    tick(1);
    w0 = wr_cnt;
    start_resp(8'h5A, 1'b0, ok);
    checks++; if (ok !== 1) begin errors++; $display("FAIL rd_handshake: got %0d want 1", ok); end
    wait_tx(w0, prem, ok);
    checks++; if (ok !== 1 || prem !== 0) begin errors++; $display("FAIL rd_completion: got done %0d early_ready %0d want 1 0", ok, prem); end
    checks++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL rd_wr_count: got %0d want 2", wr_cnt - w0); end
    checks++; if (tx_log[w0] !== 8'h5A || tx_log[w0+1] !== 8'h00) begin errors++; $display("FAIL rd_bytes: got %h %h want 5a 00", tx_log[w0], tx_log[w0+1]); end
    checks++; if (wr_busy_viol !== 0 || wr_double !== 0) begin errors++; $display("FAIL rd_strobe_rules: got busy_viol %0d double %0d want 0 0", wr_busy_viol, wr_double); end
    checks++; if ((wr_cyc_log[w0] - hs_cyc) < 2) begin errors++; $display("FAIL rd_first_latency: got %0d want >=2", wr_cyc_log[w0] - hs_cyc); end
    checks++; if ((wr_cyc_log[w0+1] - wr_cyc_log[w0]) < 8) begin errors++; $display("FAIL rd_wait_tx_done: got gap %0d want >=8", wr_cyc_log[w0+1] - wr_cyc_log[w0]); end
  endtask

  task automatic test_backpressure();
    int r0, c0, bad;
    do_reset();
    r0 = req_cnt;
    c0 = clr_cnt;
    bad = 0;
    send_frame(8'h00, 8'h40, 8'h00, 8'h00);
    checks++; if (req_valid !== 1'b1 || req_addr !== 16'h4000 || req_is_write !== 1'b0) begin
      errors++; $display("FAIL bp_hold: got valid %b addr %h w %b want 1 4000 0", req_valid, req_addr, req_is_write); end
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL bp_no_overrun_yet: got %b want 0", err_overrun); end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (req_valid !== 1'b1 || req_addr !== 16'h4000 || req_wdata !== 8'h00 || req_is_write !== 1'b0) bad++;
    end
    send_byte(8'h77);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (req_valid !== 1'b1 || req_addr !== 16'h4000 || req_wdata !== 8'h00 || req_is_write !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_payload_stable: got %0d bad cycles want 0", bad); end
    checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %b want 1", err_overrun); end
    checks++; if (clr_cnt - c0 !== 5) begin errors++; $display("FAIL bp_clr_count: got %0d want 5", clr_cnt - c0); end
    checks++; if (req_cnt - r0 !== 0) begin errors++; $display("FAIL bp_no_req_early: got %0d want 0", req_cnt - r0); end
    req_ready = 1'b1;
    tick(1);
    req_ready = 1'b0;
    checks++; if (req_valid !== 1'b0 || req_cnt - r0 !== 1 || req_addr_log[r0] !== 16'h4000) begin
      errors++; $display("FAIL bp_handshake: got valid %b cnt %0d addr %h want 0 1 4000", req_valid, req_cnt - r0, req_addr_log[r0]); end
    tick(3);
    checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun_sticky: got %b want 1", err_overrun); end
  endtask

  task automatic test_timeout();
    int r0;
    do_reset();
    req_ready = 1'b1;
    r0 = req_cnt;
    send_byte(8'h11);
    tick(13);
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_not_yet: got %b want 0", err_timeout); end
    tick(1);
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_fired: got %b want 1", err_timeout); end
    send_frame(8'h00, 8'h80, 8'hCC, 8'h01);
    tick(2);
    checks++; if (req_cnt - r0 !== 1 || req_addr_log[r0] !== 16'h8000 || req_wdata_log[r0] !== 8'hCC) begin
      errors++; $display("FAIL to_resync: got cnt %0d addr %h data %h want 1 8000 cc", req_cnt - r0, req_addr_log[r0], req_wdata_log[r0]); end
  endtask

  task automatic test_timeout_boundary();
    int r0;
    do_reset();
    req_ready = 1'b1;
    r0 = req_cnt;
    send_byte(8'h22);
    tick(13);
    send_byte(8'h33);
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tob_byte_wins: got %b want 0", err_timeout); end
    send_byte(8'h44);
    send_byte(8'h01);
    tick(2);
    checks++; if (req_cnt - r0 !== 1 || req_addr_log[r0] !== 16'h3322 || req_wdata_log[r0] !== 8'h44 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL tob_frame: got cnt %0d addr %h data %h to %b want 1 3322 44 0", req_cnt - r0, req_addr_log[r0], req_wdata_log[r0], err_timeout); end
  endtask

  task automatic test_timeout_late();
    int r0;
    do_reset();
    req_ready = 1'b1;
    r0 = req_cnt;
    send_byte(8'h55);
    tick(14);
    send_byte(8'h01);
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tol_fired: got %b want 1", err_timeout); end
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h01);
    tick(2);
    checks++; if (req_cnt - r0 !== 1 || req_addr_log[r0] !== 16'h0201 || req_wdata_log[r0] !== 8'h03) begin
      errors++; $display("FAIL tol_frame: got cnt %0d addr %h data %h want 1 0201 03", req_cnt - r0, req_addr_log[r0], req_wdata_log[r0]); end
  endtask

  task automatic test_back_to_back();
    int r0, w0, ok, prem;
    do_reset();
    req_ready = 1'b1;
    tick(1);
    r0 = req_cnt;
    w0 = wr_cnt;
    start_resp(8'hC3, 1'b1, ok);
    send_frame(8'hA5, 8'h5A, 8'h11, 8'h00);
    send_frame(8'h01, 8'h00, 8'hFF, 8'h01);
    wait_tx(w0, prem, ok);
    tick(2);
    checks++; if (ok !== 1 || tx_log[w0] !== 8'hC3 || tx_log[w0+1] !== 8'h01) begin
      errors++; $display("FAIL b2b_tx: got done %0d bytes %h %h want 1 c3 01", ok, tx_log[w0], tx_log[w0+1]); end
    checks++; if (req_cnt - r0 !== 2) begin errors++; $display("FAIL b2b_req_count: got %0d want 2", req_cnt - r0); end
    checks++; if (req_addr_log[r0] !== 16'h5AA5 || req_wdata_log[r0] !== 8'h11 || req_isw_log[r0] !== 1'b0) begin
      errors++; $display("FAIL b2b_first: got %h %h %b want 5aa5 11 0", req_addr_log[r0], req_wdata_log[r0], req_isw_log[r0]); end
    checks++; if (req_addr_log[r0+1] !== 16'h0001 || req_wdata_log[r0+1] !== 8'hFF || req_isw_log[r0+1] !== 1'b1) begin
      errors++; $display("FAIL b2b_second: got %h %h %b want 0001 ff 1", req_addr_log[r0+1], req_wdata_log[r0+1], req_isw_log[r0+1]); end
  endtask

  task automatic test_reset_midframe();
    int r0;
    req_ready = 1'b1;
    send_byte(8'h01);
    send_byte(8'h02);
    rst_n = 1'b0;
    tick(1);
    checks++; if ({req_valid, req_addr, req_wdata, req_is_write, uart_tx_data, uart_wr_en, uart_ready_clr, resp_ready, err_timeout, err_overrun} !== 39'd0) begin
      errors++; $display("FAIL mid_reset_outputs: got addr %h tx %h valid %b rr %b want all zero", req_addr, uart_tx_data, req_valid, resp_ready); end
    rst_n = 1'b1;
    r0 = req_cnt;
    send_frame(8'h10, 8'h00, 8'h22, 8'h01);
    tick(2);
    checks++; if (req_cnt - r0 !== 1 || req_addr_log[r0] !== 16'h0010 || req_wdata_log[r0] !== 8'h22) begin
      errors++; $display("FAIL mid_frame_after: got cnt %0d addr %h data %h want 1 0010 22", req_cnt - r0, req_addr_log[r0], req_wdata_log[r0]); end
  endtask

  initial begin
    test_reset();
    test_write_frame();
    test_read_response();
    test_backpressure();
    test_timeout();
    test_timeout_boundary();
    test_timeout_late();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_bridge_initiator_uart_link.md
# bus_bridge_initiator_uart_link

Far-end UART link stage of the bus bridge, located on the Bus-B side directly downstream of the Bus-A target UART wrapper. It assembles the 4-byte request frames arriving from the UART receiver (addr LSB, addr MSB, write data, flags) into a parallel request for the Bus-B initiator. It also serialises the returned 2-byte response (read data, flags) back through the UART transmitter. A frame-timeout counter resynchronises the receive framing after a dropped byte.

## Interface
- FRAME_TIMEOUT_CYCLES, 100000: maximum idle cycles between bytes of one frame; must be ≥ 2.
- clk  in  1  single system clock (same clock as the UART).
- rst_n  in  1  reset, synchronous, active-low.
- uart_rx_ready  in  1  UART receiver byte-available level; stays high until cleared.
- uart_rx_data  in  8  UART received byte; valid while uart_rx_ready is high.
- uart_ready_clr  out  1  one-cycle pulse that clears uart_rx_ready.
- uart_tx_data  out  8  byte to transmit.
- uart_wr_en  out  1  one-cycle transmit strobe.
- uart_tx_busy  in  1  UART transmitter busy.
- req_valid  out  1  request available.
- req_ready  in  1  Bus-B initiator accepts the request.
- req_addr  out  16  request address, {byte1, byte0}.
- req_wdata  out  8  request write data (byte2).
- req_is_write  out  1  byte3 bit 0.
- resp_valid  in  1  response available.
- resp_ready  out  1  link can take a response.
- resp_rdata  in  8  response read data.
- resp_is_write  in  1  response type flag.
- err_timeout  out  1  sticky: a partial frame was discarded on timeout.
- err_overrun  out  1  sticky: a byte arrived while a request was held and was discarded.

## Operation
- Byte detect:
  - rx_q register holds the previous uart_rx_ready.
  - A new byte is defined as uart_rx_ready && !rx_q.
  - Every detected byte pulses uart_ready_clr in the following cycle, including discarded bytes.
- RX FSM states: RX_ADDR_L → RX_ADDR_H → RX_DATA → RX_FLAGS → RX_HOLD → RX_ADDR_L.
  - Each of the first four states captures a byte on detect and advances to the next state.
  - The byte captured in RX_FLAGS uses bit 0 only; bits 7:1 are ignored.
  - RX_HOLD: req_valid=1. The payload stays stable until req_valid && req_ready, then the FSM returns to RX_ADDR_L.
  - A byte detected in RX_HOLD is discarded and sets err_overrun.
- Timeout:
  - The counter is $clog2(FRAME_TIMEOUT_CYCLES+1) bits wide. It clears on every detected byte and counts only in RX_ADDR_H, RX_DATA and RX_FLAGS.
  - When the count reaches FRAME_TIMEOUT_CYCLES-1 with no byte that cycle, the FSM goes to RX_ADDR_L, clears the counter and sets err_timeout.
  - If a byte arrives in the expiry cycle, the byte wins: it is accepted and the timeout does not fire.
  - The counter saturates; it never wraps.
- TX FSM states: TX_IDLE, TX_SEND_DATA, TX_WAIT_DATA, TX_SEND_FLAGS, TX_WAIT_FLAGS.
  - resp_ready = (state == TX_IDLE).
  - On resp_valid && resp_ready, latch resp_rdata and resp_is_write, then go to TX_SEND_DATA.
  - SEND_* states: when !uart_tx_busy, drive uart_tx_data and pulse uart_wr_en for 1 cycle, then go to WAIT_*.
  - WAIT_* states wait for tx_done = busy_d && !uart_tx_busy.
  - Byte 0 is the read data. Byte 1 is {7'b0, is_write}.
  - After TX_WAIT_FLAGS the FSM returns to TX_IDLE.
- RX and TX are independent. A new request frame may be received while a response is being transmitted.
- Sticky errors clear only on reset.

## Timing
- Reset (rst_n low at a clk edge):
  - All outputs go to 0: req_*, uart_tx_data, uart_wr_en, uart_ready_clr, resp_ready→0 until the first cycle after reset, err_*.
  - The FSMs go to RX_ADDR_L and TX_IDLE; rx_q, busy_d and the counter go to 0.
  - A partial frame or in-flight response is dropped.
  - If uart_rx_ready is high at reset release, it is detected as a new byte in RX_ADDR_L.
- From a uart_rx_ready rise on the flags byte (cycle N):
  - uart_ready_clr is high in cycle N+1.
  - req_valid is high in cycle N+1.
- Handshake completes in the cycle req_valid && req_ready are both high. req_valid is low the next cycle.
- From a response handshake (cycle M), the first uart_wr_en pulse is no earlier than cycle M+2.
- Minimum request turnaround: one idle cycle after req handshake before a new byte can be captured.

## Test plan
- Write frame: bytes 34,12,AB,01 with req_ready=1 → one req_valid pulse; addr=0x1234, wdata=0xAB, is_write=1; four uart_ready_clr pulses.
- Read response: resp_valid with rdata=0x5A, is_write=0 → tx bytes 0x5A then 0x00, each a single uart_wr_en pulse; the second pulse only after tx_done; resp_ready low throughout.
- Backpressure: frame 00,40,00,00 with req_ready=0 for 20 cycles → payload stable (addr 0x4000, is_write=0) until the handshake; an extra byte 0x77 sent during this → err_overrun=1, payload unchanged.
- Timeout resync:
  - FRAME_TIMEOUT_CYCLES=16; send byte 0x11 then stall 16 cycles → err_timeout=1, no req.
  - Then send 00,80,CC,01 → addr=0x8000, wdata=0xCC.
- Timeout boundary: second byte arrives exactly in the expiry cycle → accepted, err_timeout stays 0.
- Reset mid-frame: 2 bytes sent, rst_n low 1 cycle, then a full frame 10,00,22,01 → exactly one req with addr=0x0010; all outputs 0 during reset.
